hd44780_sequencer: RTL and testbench

Controller between the syscon and the LCD nybble bus writer. After reset it runs the HD44780 4-bit-mode power-on initialisation: timed 0x3/0x3/0x3/0x2 nybbles, then five configuration bytes. It then accepts host byte commands one at a time, splitting each into high and low nybbles and enforcing the controller's execution delays. It drives a downstream nybble writer through a strobe/ack handshake, and its clock and reset come from the syscon's CLK_O/RST_O.

---
 rtl/hd44780_pkg.sv | 43 ++++
 rtl/hd44780_wait_timer.sv | 26 ++
 rtl/hd44780_sequencer.sv | 167 ++++++++++++++++
 tb/tb_hd44780_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared FSM states, init constants and helpers for the HD44780 sequencer
package hd44780_pkg;

    typedef enum logic [2:0] {
        PWRUP_WAIT,
        INIT_NYB,
        INIT_WAIT,
        BYTE_HI,
        GAP_WAIT,
        BYTE_LO,
        BYTE_WAIT,
        READY
    } state_t;

    localparam logic [7:0] FUNCSET_4BIT = 8'h28;
    localparam logic [7:0] DISP_OFF     = 8'h08;
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] ENTRY_INC    = 8'h06;
    localparam logic [7:0] DISP_ON      = 8'h0C;

    localparam logic [3:0] INIT_NYB_3 = 4'h3;
    localparam logic [3:0] INIT_NYB_2 = 4'h2;

    localparam logic [2:0] LAST_INIT_BYTE = 3'd4;

    // Configuration byte sent at position idx of the init byte sequence
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        return idx == 3'd0 ? FUNCSET_4BIT :
               idx == 3'd1 ? DISP_OFF :
               idx == 3'd2 ? CLEAR :
               idx == 3'd3 ? ENTRY_INC : DISP_ON;
    endfunction

    // Clear display and return home (0x01..0x03 as instructions) need the long execution delay
    function automatic logic needs_clr_wait(input logic [7:0] data, input logic rs);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/hd44780_wait_timer.sv
// hd44780_wait_timer: loadable down-counter flagging when a wait has run out
// Ports: clk, rst (sync, active-high), load/value (start a wait), expired (count is zero)
module hd44780_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = count == '0;

endmodule

// File: rtl/hd44780_sequencer.sv
// hd44780_sequencer: HD44780 4-bit power-on init plus host byte commands over a nybble strobe/ack bus
// Ports: CLK_I/RST_I from syscon; i_cmd_* host byte request; o_busy/o_ready/o_cmd_done host status;
//        o_nyb_stb/o_nyb/o_rs request to the nybble writer, i_nyb_ack its completion pulse
module hd44780_sequencer
    import hd44780_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 600000,
    parameter int LONG_WAIT_CYCLES  = 49200,
    parameter int SHORT_WAIT_CYCLES = 1200,
    parameter int CMD_WAIT_CYCLES   = 444,
    parameter int CLR_WAIT_CYCLES   = 18240,
    parameter int NYB_GAP_CYCLES    = 12
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_cmd_stb,
    input  logic [7:0] i_cmd_data,
    input  logic       i_cmd_rs,
    output logic       o_busy,
    output logic       o_ready,
    output logic       o_cmd_done,
    output logic       o_nyb_stb,
    output logic [3:0] o_nyb,
    output logic       o_rs,
    input  logic       i_nyb_ack
);

    localparam int MAX_WAIT = max_int(max_int(max_int(POWERUP_CYCLES, LONG_WAIT_CYCLES),
                                              max_int(SHORT_WAIT_CYCLES, CMD_WAIT_CYCLES)),
                                      max_int(CLR_WAIT_CYCLES, NYB_GAP_CYCLES));
    localparam int CW = $clog2(MAX_WAIT + 1);
    // One cycle is spent arming the timer and one turning expiry into the strobe
    localparam int PWRUP_LOAD = POWERUP_CYCLES > 1 ? POWERUP_CYCLES - 2 : 0;

    state_t        state;
    logic          armed;
    logic [1:0]    init_idx;
    logic [2:0]    byte_idx;
    logic [7:0]    cur_byte;
    logic          cur_rs;

    logic [CW-1:0] wait_len;
    logic [CW-1:0] timer_val;
    logic          timer_load;
    logic          expired;
    logic          acked;
    logic          go;
    logic [7:0]    next_init;

    state_t        adv_state;
    logic [3:0]    adv_nyb;
    logic [1:0]    adv_init_idx;
    logic [2:0]    adv_byte_idx;
    logic [7:0]    adv_byte;

    assign acked     = o_nyb_stb && i_nyb_ack;
    assign next_init = init_byte(byte_idx + 3'd1);

    // Wait that follows the nybble currently on the bus
    assign wait_len = state == INIT_NYB ? (init_idx == 2'd0 ? CW'(LONG_WAIT_CYCLES) : CW'(SHORT_WAIT_CYCLES)) :
                      state == BYTE_HI  ? CW'(NYB_GAP_CYCLES) :
                      needs_clr_wait(cur_byte, cur_rs) ? CW'(CLR_WAIT_CYCLES) : CW'(CMD_WAIT_CYCLES);

    // Loading W-1 at the ack lands the next strobe W+1 cycles after it; a zero wait advances straight from the ack
    assign go = acked ? wait_len == '0 :
                expired && (state == INIT_WAIT || state == GAP_WAIT || state == BYTE_WAIT ||
                            (state == PWRUP_WAIT && armed));
    assign timer_load = acked || (state == PWRUP_WAIT && !armed);
    assign timer_val  = state == PWRUP_WAIT ? CW'(PWRUP_LOAD) : wait_len - 1'b1;

    hd44780_wait_timer #(.W(CW)) u_timer (
        .clk     (CLK_I),
        .rst     (RST_I),
        .load    (timer_load),
        .value   (timer_val),
        .expired (expired)
    );

    // Where the sequence goes once the current wait has finished
    always_comb begin
        adv_state    = READY;
        adv_nyb      = 4'h0;
        adv_init_idx = init_idx;
        adv_byte_idx = byte_idx;
        adv_byte     = cur_byte;
        case (state)
            PWRUP_WAIT: begin
                adv_state    = INIT_NYB;
                adv_nyb      = INIT_NYB_3;
                adv_init_idx = 2'd0;
            end
            INIT_NYB, INIT_WAIT: begin
                if (init_idx == 2'd3) begin
                    adv_state    = BYTE_HI;
                    adv_nyb      = FUNCSET_4BIT[7:4];
                    adv_byte_idx = 3'd0;
                    adv_byte     = FUNCSET_4BIT;
                end else begin
                    adv_state    = INIT_NYB;
                    adv_nyb      = init_idx == 2'd2 ? INIT_NYB_2 : INIT_NYB_3;
                    adv_init_idx = init_idx + 2'd1;
                end
            end
            BYTE_HI, GAP_WAIT: begin
                adv_state = BYTE_LO;
                adv_nyb   = cur_byte[3:0];
            end
            BYTE_LO, BYTE_WAIT: begin
                if (!o_ready && byte_idx != LAST_INIT_BYTE) begin
                    adv_state    = BYTE_HI;
                    adv_nyb      = next_init[7:4];
                    adv_byte_idx = byte_idx + 3'd1;
                    adv_byte     = next_init;
                end
            end
            default: adv_state = READY;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state      <= PWRUP_WAIT;
            armed      <= 1'b0;
            init_idx   <= 2'd0;
            byte_idx   <= 3'd0;
            cur_byte   <= 8'h00;
            cur_rs     <= 1'b0;
            o_nyb_stb  <= 1'b0;
            o_nyb      <= 4'h0;
            o_rs       <= 1'b0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
            o_cmd_done <= 1'b0;
        end else begin
            o_cmd_done <= 1'b0;
            if (go) begin
                state     <= adv_state;
                init_idx  <= adv_init_idx;
                byte_idx  <= adv_byte_idx;
                cur_byte  <= adv_byte;
                o_nyb_stb <= adv_state != READY;
                o_nyb     <= adv_nyb;
                o_rs      <= adv_state == BYTE_LO && cur_rs;
                if (adv_state == READY) begin
                    o_ready    <= 1'b1;
                    o_busy     <= 1'b0;
                    // Only a host command reports completion; the end of init does not
                    o_cmd_done <= o_ready;
                end
            end else if (acked) begin
                o_nyb_stb <= 1'b0;
                state     <= state == INIT_NYB ? INIT_WAIT : state == BYTE_HI ? GAP_WAIT : BYTE_WAIT;
            end else if (state == PWRUP_WAIT) begin
                armed <= 1'b1;
            end else if (state == READY && i_cmd_stb) begin
                state     <= BYTE_HI;
                cur_byte  <= i_cmd_data;
                cur_rs    <= i_cmd_rs;
                o_busy    <= 1'b1;
                o_nyb_stb <= 1'b1;
                o_nyb     <= i_cmd_data[7:4];
                o_rs      <= i_cmd_rs;
            end
        end
    end

endmodule

// File: tb/tb_hd44780_sequencer.sv
// tb_hd44780_sequencer: event-level model of the init/command nybble stream checked every cycle, plus literal timing pins
module tb_hd44780_sequencer;

    localparam int P    = 20;
    localparam int L    = 10;
    localparam int S    = 4;
    localparam int CMDW = 3;
    localparam int CLRW = 8;
    localparam int G    = 1;

    typedef struct {
        logic [3:0] nyb;
        logic       rs;
        int         w;
    } item_t;

    logic       clk = 1'b0;
    logic       RST_I = 1'b1;
    logic       i_cmd_stb = 1'b0;
    logic [7:0] i_cmd_data = 8'h00;
    logic       i_cmd_rs = 1'b0;
    logic       i_nyb_ack = 1'b0;
    logic       o_busy, o_ready, o_cmd_done, o_nyb_stb, o_rs;
    logic [3:0] o_nyb;

    hd44780_sequencer #(
        .POWERUP_CYCLES    (P),
        .LONG_WAIT_CYCLES  (L),
        .SHORT_WAIT_CYCLES (S),
        .CMD_WAIT_CYCLES   (CMDW),
        .CLR_WAIT_CYCLES   (CLRW),
        .NYB_GAP_CYCLES    (G)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (RST_I),
        .i_cmd_stb  (i_cmd_stb),
        .i_cmd_data (i_cmd_data),
        .i_cmd_rs   (i_cmd_rs),
        .o_busy     (o_busy),
        .o_ready    (o_ready),
        .o_cmd_done (o_cmd_done),
        .o_nyb_stb  (o_nyb_stb),
        .o_nyb      (o_nyb),
        .o_rs       (o_rs),
        .i_nyb_ack  (i_nyb_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int c = 0;

    logic       rst_req = 1'b1;
    logic       cmd_req = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_rs = 1'b0;
    logic       spur = 1'b0;
    int         age = 0;
    logic       ack;

    logic  prev_rst = 1'b1;
    logic  m_stb = 1'b0, m_busy = 1'b1, m_ready = 1'b0, m_done = 1'b0;
    int    rise_at = -1, end_at = -1, rel = -1;
    logic  end_is_cmd = 1'b0;
    item_t exp_q[$];
    item_t cur;

    int         rise_log[$];
    logic [3:0] nyb_log[$];
    logic       rs_log[$];
    int         done_log[$];
    int         ready_at = -1;
    logic       prev_dut_stb = 1'b0, prev_dut_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, c);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic rs);
        item_t it;
        it.nyb = d[7:4]; it.rs = rs; it.w = G;
        exp_q.push_back(it);
        it.nyb = d[3:0]; it.w = (!rs && d >= 8'h01 && d <= 8'h03) ? CLRW : CMDW;
        exp_q.push_back(it);
    endtask

    task automatic push_init();
        logic [7:0] ib [5] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
        int         iw [4] = '{L, S, S, S};
        item_t      it;
        for (int i = 0; i < 4; i++) begin
            it.nyb = i == 3 ? 4'h2 : 4'h3; it.rs = 1'b0; it.w = iw[i];
            exp_q.push_back(it);
        end
        for (int i = 0; i < 5; i++) push_byte(ib[i], 1'b0);
    endtask

    task automatic clear_logs();
        rise_log.delete(); nyb_log.delete(); rs_log.delete(); done_log.delete();
        ready_at = -1;
    endtask

    // One clock cycle: compare outputs against the model, drive inputs, then advance the model
    task automatic tick();
        @(negedge clk);
        c++;
        if (!prev_rst && rise_at == c) begin
            m_stb = 1'b1;
            cur = exp_q.pop_front();
        end
        m_done = 1'b0;
        if (!prev_rst && end_at == c) begin
            m_busy = 1'b0;
            m_ready = 1'b1;
            m_done = end_is_cmd;
        end
        chk("nyb_stb", o_nyb_stb, m_stb);
        chk("busy", o_busy, m_busy);
        chk("ready", o_ready, m_ready);
        chk("cmd_done", o_cmd_done, m_done);
        if (m_stb) begin
            chk("nyb", o_nyb, cur.nyb);
            chk("rs", o_rs, cur.rs);
        end
        if (prev_rst) begin
            chk("nyb_rst", o_nyb, 0);
            chk("rs_rst", o_rs, 0);
        end
        if (o_nyb_stb && !prev_dut_stb) begin
            rise_log.push_back(c); nyb_log.push_back(o_nyb); rs_log.push_back(o_rs);
        end
        if (o_cmd_done) done_log.push_back(c);
        if (o_ready && !prev_dut_ready) ready_at = c;
        prev_dut_stb = o_nyb_stb;
        prev_dut_ready = o_ready;
        age = o_nyb_stb ? age + 1 : 0;
        ack = !rst_req && (o_nyb_stb ? age == 3 : spur);
        RST_I = rst_req;
        i_nyb_ack = ack;
        i_cmd_stb = cmd_req;
        i_cmd_data = cmd_data;
        i_cmd_rs = cmd_rs;
        if (rst_req) begin
            m_stb = 1'b0; m_busy = 1'b1; m_ready = 1'b0;
            rise_at = -1; end_at = -1;
            exp_q.delete();
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                push_init();
                rise_at = c + P;
                rel = c;
            end
            if (m_stb && ack) begin
                m_stb = 1'b0;
                if (exp_q.size() > 0) rise_at = c + 1 + cur.w;
                else begin
                    end_at = c + 1 + cur.w;
                    end_is_cmd = m_ready;
                end
            end
            if (!m_busy && cmd_req) begin
                push_byte(cmd_data, cmd_rs);
                rise_at = c + 1;
                m_busy = 1'b1;
            end
            prev_rst = 1'b0;
        end
    endtask

    function automatic logic met(input int kind, input int n);
        return kind == 0 ? ready_at >= 0 : kind == 1 ? done_log.size() >= n : rise_log.size() >= n;
    endfunction

    task automatic wait_until(input string name, input int kind, input int n, input int budget);
        int i = 0;
        while (!met(kind, n) && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (!met(kind, n)) begin
            errors++;
            $display("FAIL %s: not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic rs);
        cmd_req = 1'b1; cmd_data = d; cmd_rs = rs;
    endtask

    initial begin
        int         acc;
        logic [3:0] init_nyb [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
        int         init_gap [13] = '{13, 7, 7, 7, 4, 6, 4, 6, 4, 11, 4, 6, 4};
        logic [3:0] b2b_nyb [4]   = '{4'h4, 4'h8, 4'h4, 4'h9};

        repeat (3) tick();
        clear_logs();
        rst_req = 1'b0;
        wait_until("init_ready", 0, 0, 400);
        chk("first_rise", rise_log[0], rel + 20);
        chk("first_nyb", nyb_log[0], 4'h3);
        chk("first_rs", rs_log[0], 1'b0);
        chk("init_count", nyb_log.size(), 14);
        for (int k = 0; k < 14; k++) chk("init_nyb", nyb_log[k], init_nyb[k]);
        for (int k = 0; k < 13; k++) chk("init_gap", rise_log[k+1] - rise_log[k], init_gap[k]);
        chk("ready_at", ready_at, rise_log[13] + 6);
        chk("busy_after_init", o_busy, 1'b0);

        clear_logs();
        send(8'h41, 1'b1);
        tick();
        acc = c;
        cmd_req = 1'b0;
        wait_until("done_41", 1, 1, 100);
        chk("d41_hi_rise", rise_log[0], acc + 1);
        chk("d41_hi", nyb_log[0], 4'h4);
        chk("d41_hi_rs", rs_log[0], 1'b1);
        chk("d41_lo_rise", rise_log[1], acc + 5);
        chk("d41_lo", nyb_log[1], 4'h1);
        chk("d41_lo_rs", rs_log[1], 1'b1);
        chk("d41_done", done_log[0], rise_log[1] + 6);
        repeat (2) tick();

        clear_logs();
        spur = 1'b1;
        send(8'h01, 1'b0);
        tick();
        acc = c;
        cmd_req = 1'b0;
        repeat (2) tick();
        send(8'h55, 1'b1);
        tick();
        cmd_req = 1'b0;
        wait_until("done_clr", 1, 1, 100);
        repeat (5) tick();
        spur = 1'b0;
        chk("clr_count", nyb_log.size(), 2);
        chk("clr_hi_rise", rise_log[0], acc + 1);
        chk("clr_hi", nyb_log[0], 4'h0);
        chk("clr_lo", nyb_log[1], 4'h1);
        chk("clr_done", done_log[0], rise_log[1] + 11);
        chk("clr_done_count", done_log.size(), 1);

        clear_logs();
        send(8'h48, 1'b1);
        tick();
        cmd_data = 8'h49;
        wait_until("b2b_first", 1, 1, 100);
        cmd_req = 1'b0;
        wait_until("b2b_second", 1, 2, 100);
        chk("b2b_count", nyb_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("b2b_nyb", nyb_log[k], b2b_nyb[k]);
        chk("b2b_no_gap", rise_log[2], done_log[0] + 1);
        chk("b2b_done2", done_log[1], rise_log[3] + 6);

        clear_logs();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        wait_until("reinit_08", 2, 7, 200);
        chk("mid_init_nyb", nyb_log[6], 4'h0);
        tick();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        clear_logs();
        tick();
        chk("rst_init_stb", o_nyb_stb, 1'b0);
        chk("rst_init_busy", o_busy, 1'b1);
        chk("rst_init_ready", o_ready, 1'b0);
        wait_until("reinit_ready", 0, 0, 400);
        chk("reinit_first_rise", rise_log[0], rel + 20);
        chk("reinit_count", nyb_log.size(), 14);

        send(8'h41, 1'b1);
        tick();
        cmd_req = 1'b0;
        repeat (3) tick();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        clear_logs();
        tick();
        chk("rst_cmd_stb", o_nyb_stb, 1'b0);
        chk("rst_cmd_busy", o_busy, 1'b1);
        chk("rst_cmd_ready", o_ready, 1'b0);
        wait_until("recmd_ready", 0, 0, 400);
        chk("recmd_first_rise", rise_log[0], rel + 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
